// File: rtl/mfp_spi_slave_pkg.sv
// Shared defaults and FSM state encoding for the mfp_spi_slave block.
package mfp_spi_slave_pkg;

  localparam int         DEF_DATA_WIDTH  = 8;
  localparam int         DEF_SYNC_STAGES = 2;
  localparam logic [7:0] DEF_DEFAULT_TX  = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/mfp_spi_slave_sync.sv
// N-stage synchronizer with rise/fall pulses taken from the last stage versus one extra delay flop.
// Latency STAGES cycles to o_q; pulses valid one cycle, no backpressure.
module mfp_spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/mfp_spi_slave.sv
// SPI mode-0 responder oversampled in the clk domain: parallel RX stream plus single-entry TX holding register.
// rx_valid ~SYNC_STAGES+1 clk after the last SCLK rise; tx_ready low while the holding register is full.
module mfp_spi_slave
  import mfp_spi_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(DEF_DEFAULT_TX)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spi_sclk,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
  logic w_ss_rise, w_ss_fall, w_ss_level_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  mfp_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .i_d(spi_sclk),
    .o_q(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // SS_N chain resets low so a select held low through reset is never taken as a fresh frame start.
  mfp_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .clk(clk), .resetn(resetn), .i_d(spi_ss_n),
    .o_q(w_ss_level_unused), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  mfp_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .resetn(resetn), .i_d(spi_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_reload_pending;
  logic                  r_dflt_pending;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_rx_next = {r_rx_shift, w_mosi};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_rx_shift       <= '0;
      r_tx_shift       <= '0;
      r_hold           <= '0;
      r_hold_full      <= 1'b0;
      r_reload_pending <= 1'b0;
      r_dflt_pending   <= 1'b0;
      r_rx_data        <= '0;
      r_rx_valid       <= 1'b0;
      r_underrun       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state          <= ST_ACTIVE;
            r_cnt            <= '0;
            r_reload_pending <= 1'b0;
            r_dflt_pending   <= 1'b0;
            if (r_hold_full) begin
              r_tx_shift  <= r_hold;
              r_hold_full <= 1'b0;
            end else begin
              r_tx_shift <= DEFAULT_TX;
              r_underrun <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_reload_pending <= 1'b0;
            r_dflt_pending   <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
            // A default word loaded at a boundary only counts as an underrun once the master clocks it.
            if (r_dflt_pending) begin
              r_underrun     <= 1'b1;
              r_dflt_pending <= 1'b0;
            end
            if (r_cnt == CW'(DATA_WIDTH - 1)) begin
              r_rx_data        <= w_rx_next;
              r_rx_valid       <= 1'b1;
              r_cnt            <= '0;
              r_reload_pending <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (w_sclk_fall) begin
            if (r_reload_pending) begin
              r_reload_pending <= 1'b0;
              if (r_hold_full) begin
                r_tx_shift  <= r_hold;
                r_hold_full <= 1'b0;
              end else begin
                r_tx_shift     <= DEFAULT_TX;
                r_dflt_pending <= 1'b1;
              end
            end else begin
              r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A load only consumes a full register, so a write accepted here never collides with it.
      if (tx_valid && !r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign busy        = (r_state == ST_ACTIVE);
  assign spi_miso_oe = (r_state == ST_ACTIVE);
  assign spi_miso    = (r_state == ST_ACTIVE) & r_tx_shift[DATA_WIDTH-1];
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_mfp_spi_slave.sv
// Bench for mfp_spi_slave: word-level TX/RX model, per-cycle output monitor, directed and random frames.
module tb_mfp_spi_slave;

  localparam int H = 4;  // SCLK half period in clk cycles (SCLK = clk/8)

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  mfp_spi_slave dut (
    .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Word-level model: holding register, expected RX words, underrun tally.
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] exp_rx[$];
  int         exp_unr = 0;
  int         obs_unr = 0;
  int         obs_rx = 0;
  logic [7:0] mon_e;

  logic [7:0] f_mosi[4];
  bit         f_wr[4];
  logic [7:0] f_wrv[4];
  logic [7:0] got_miso[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_miso", {31'd0, spi_miso}, 0);
      check("rst_oe", {31'd0, spi_miso_oe}, 0);
      check("rst_tx_ready", {31'd0, tx_ready}, 1);
      check("rst_rx_data", {24'd0, rx_data}, 0);
      check("rst_rx_valid", {31'd0, rx_valid}, 0);
      check("rst_underrun", {31'd0, tx_underrun}, 0);
      check("rst_busy", {31'd0, busy}, 0);
    end else begin
      if (rx_valid) begin
        obs_rx++;
        if (exp_rx.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got rx_valid with %0h, expected none", rx_data);
        end else begin
          mon_e = exp_rx.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, mon_e});
        end
      end
      if (tx_underrun) obs_unr++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] v);
    int t = 0;
    while (!tx_ready && t < 50) begin
      wait_cyc(1);
      t++;
    end
    if (!tx_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL tx_ready_timeout: got tx_ready=0, expected 1 within 50 cycles");
      return;
    end
    tx_data  = v;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid    = 1'b0;
    m_hold      = v;
    m_hold_full = 1'b1;
    check("tx_ready_after_write", {31'd0, tx_ready}, 0);
  endtask

  task automatic run_frame(input int nbits, input bit end_ss);
    logic [7:0] cur, nxt;
    bit         nxt_dflt;
    int         k, i;
    spi_ss_n = 1'b0;
    if (m_hold_full) begin
      cur = m_hold;
      m_hold_full = 1'b0;
    end else begin
      cur = 8'hFF;
      exp_unr++;
    end
    nxt = 8'hFF;
    nxt_dflt = 1'b1;
    wait_cyc(4);
    check("tx_ready_after_ss", {31'd0, tx_ready}, 1);
    for (int b = 0; b < nbits; b++) begin
      k = b / 8;
      i = b % 8;
      if (i == 0 && k > 0) begin
        cur = nxt;
        if (nxt_dflt) exp_unr++;
      end
      spi_mosi = f_mosi[k][7-i];
      wait_cyc(H);
      check("miso_bit", {31'd0, spi_miso}, {31'd0, cur[7-i]});
      got_miso[k][7-i] = spi_miso;
      check("busy_oe_active", {30'd0, busy, spi_miso_oe}, 3);
      spi_sclk = 1'b1;
      if (i == 7) exp_rx.push_back(f_mosi[k]);
      if (i == 3 && f_wr[k] && (k + 1) * 8 < nbits) begin
        wait_cyc(1);
        tx_write(f_wrv[k]);
      end
      wait_cyc(H);
      spi_sclk = 1'b0;
      if (i == 7) begin
        if (m_hold_full) begin
          nxt = m_hold;
          nxt_dflt = 1'b0;
          m_hold_full = 1'b0;
        end else begin
          nxt = 8'hFF;
          nxt_dflt = 1'b1;
        end
      end
    end
    wait_cyc(H);
    if (end_ss) begin
      spi_ss_n = 1'b1;
      wait_cyc(8);
      check("idle_busy_oe_miso", {29'd0, busy, spi_miso_oe, spi_miso}, 0);
    end
    spi_mosi = 1'b0;
  endtask

  task automatic clear_frame();
    for (int j = 0; j < 4; j++) begin
      f_mosi[j] = 8'h00;
      f_wr[j]   = 1'b0;
      f_wrv[j]  = 8'h00;
    end
  endtask

  initial begin
    int u0, r0, nw;
    clear_frame();

    // reset while idle
    wait_cyc(5);
    resetn = 1'b1;
    wait_cyc(1);
    check("tx_ready_post_reset", {31'd0, tx_ready}, 1);
    check("busy_post_reset", {31'd0, busy}, 0);

    // single word
    tx_write(8'hA5);
    f_mosi[0] = 8'h3C;
    u0 = obs_unr; r0 = obs_rx;
    run_frame(8, 1);
    check("single_miso_word", {24'd0, got_miso[0]}, 32'hA5);
    check("single_rx_data", {24'd0, rx_data}, 32'h3C);
    check("single_rx_count", obs_rx - r0, 1);
    check("single_no_underrun", obs_unr - u0, 0);

    // underrun
    f_mosi[0] = 8'h96;
    u0 = obs_unr;
    run_frame(8, 1);
    check("underrun_miso_word", {24'd0, got_miso[0]}, 32'hFF);
    check("underrun_rx_data", {24'd0, rx_data}, 32'h96);
    check("underrun_pulses", obs_unr - u0, 1);

    // back-to-back
    tx_write(8'h12);
    f_mosi[0] = 8'hC3; f_mosi[1] = 8'h5A;
    f_wr[0] = 1'b1; f_wrv[0] = 8'h34;
    u0 = obs_unr; r0 = obs_rx;
    run_frame(16, 1);
    check("b2b_miso_word0", {24'd0, got_miso[0]}, 32'h12);
    check("b2b_miso_word1", {24'd0, got_miso[1]}, 32'h34);
    check("b2b_rx_data", {24'd0, rx_data}, 32'h5A);
    check("b2b_rx_count", obs_rx - r0, 2);
    check("b2b_no_underrun", obs_unr - u0, 0);
    clear_frame();

    // abort after 5 bits, then a clean frame
    f_mosi[0] = 8'hF0;
    r0 = obs_rx;
    run_frame(5, 1);
    check("abort_no_rx", obs_rx - r0, 0);
    f_mosi[0] = 8'h81;
    run_frame(8, 1);
    check("after_abort_rx_data", {24'd0, rx_data}, 32'h81);

    // reset mid-frame after 3 bits
    f_mosi[0] = 8'hCA;
    run_frame(3, 0);
    resetn = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    m_hold_full = 1'b0;
    wait_cyc(1);
    check("midrst_tx_ready", {31'd0, tx_ready}, 1);
    check("midrst_busy_oe", {30'd0, busy, spi_miso_oe}, 0);
    spi_ss_n = 1'b1;
    wait_cyc(8);
    f_mosi[0] = 8'h7E;
    run_frame(8, 1);
    check("midrst_rx_data", {24'd0, rx_data}, 32'h7E);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      clear_frame();
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) begin
        f_mosi[j] = 8'($urandom);
        f_wr[j]   = 1'($urandom_range(0, 1));
        f_wrv[j]  = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      run_frame(nw * 8, 1);
    end

    wait_cyc(10);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("underrun_total", obs_unr, exp_unr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
